life_engine: RTL and testbench

- Holds the Game of Life board as a 20 x 15 grid of cells, one cell per 32 x 32 sprite.
- Computes one generation per `step` request, scanning one cell per clock.
- Sits directly upstream of the sprite/pixel colour stage. That stage reads `rd_alive` for the sprite it is drawing.
- Double-buffered: the displayed board changes only at the end of a complete generation, never mid-scan.

---
 rtl/life_engine.sv | 128 ++++++++++++
 tb/tb_life_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Game of Life engine: 20x15 double-buffered board, one cell evaluated per clock.
// The displayed board (cur) only changes in the single SWAP cycle after a full scan.
module life_engine #(
  parameter int COLS  = 20,
  parameter int ROWS  = 15,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load_en,
  input  logic [4:0]       load_x,
  input  logic [3:0]       load_y,
  input  logic             load_val,
  input  logic [4:0]       rd_x,
  input  logic [3:0]       rd_y,
  output logic             rd_alive,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  localparam logic [4:0] LAST_X = 5'(COLS - 1);
  localparam logic [3:0] LAST_Y = 4'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

  state_t state, state_next;
  logic [4:0] cx;
  logic [3:0] cy;
  logic [ROWS-1:0][COLS-1:0] cur, nxt;

  logic [4:0] x_l, x_r;
  logic [3:0] y_u, y_d;
  logic       ok_l, ok_r, ok_u, ok_d;
  logic [7:0] nb;
  logic [3:0] count;
  logic       alive_next;
  logic       last_cell;

  // Neighbour coordinates wrap; the ok_* flags mask off-board neighbours when WRAP=0.
  always_comb begin
    x_l  = (cx == '0)     ? LAST_X : cx - 5'd1;
    x_r  = (cx == LAST_X) ? '0     : cx + 5'd1;
    y_u  = (cy == '0)     ? LAST_Y : cy - 4'd1;
    y_d  = (cy == LAST_Y) ? '0     : cy + 4'd1;
    ok_l = (WRAP != 0) || (cx != '0);
    ok_r = (WRAP != 0) || (cx != LAST_X);
    ok_u = (WRAP != 0) || (cy != '0);
    ok_d = (WRAP != 0) || (cy != LAST_Y);
  end

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first or full if/else); otherwise synthesis infers a latch.
  always_comb begin
    nb[0] = cur[y_u][x_l] & ok_u & ok_l;
    nb[1] = cur[y_u][cx]  & ok_u;
    nb[2] = cur[y_u][x_r] & ok_u & ok_r;
    nb[3] = cur[cy][x_l]  & ok_l;
    nb[4] = cur[cy][x_r]  & ok_r;
    nb[5] = cur[y_d][x_l] & ok_d & ok_l;
    nb[6] = cur[y_d][cx]  & ok_d;
    nb[7] = cur[y_d][x_r] & ok_d & ok_r;
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, nb[i]};
    end
    alive_next = (count == 4'd3) | (cur[cy][cx] & (count == 4'd2));
  end

  assign last_cell = (cx == LAST_X) && (cy == LAST_Y);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (step) state_next = SCAN;
      SCAN:    if (last_cell) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == SWAP);

  assign rd_alive = (rd_x <= LAST_X && rd_y <= LAST_Y) ? cur[rd_y][rd_x] : 1'b0;

  // NOTE: non-blocking assignments for all sequential state, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      // NOTE: both boards are cleared by reset because a reset must leave an
      // all-dead display; this forces them into flops rather than RAM.
      cur       <= '0;
      nxt       <= '0;
      gen_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (load_en && load_x <= LAST_X && load_y <= LAST_Y)
            cur[load_y][load_x] <= load_val;
          cx <= '0;
          cy <= '0;
        end
        SCAN: begin
          nxt[cy][cx] <= alive_next;
          if (cx == LAST_X) begin
            cx <= '0;
            cy <= (cy == LAST_Y) ? '0 : cy + 4'd1;
          end else begin
            cx <= cx + 5'd1;
          end
        end
        SWAP: begin
          cur       <= nxt;
          gen_count <= gen_count + GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench: a toroidal and a flat-edged engine share stimulus and are
// compared against a plain array model of the B3/S23 rule.
module tb_life_engine;

  localparam int COLS = 20;
  localparam int ROWS = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic        load_en = 1'b0;
  logic [4:0]  load_x = '0;
  logic [3:0]  load_y = '0;
  logic        load_val = 1'b0;
  logic [4:0]  rd_x = '0;
  logic [3:0]  rd_y = '0;
  logic [1:0]  rd_alive, busy, done;
  logic [15:0] gc_w, gc_n;

  int passed = 0;
  int total  = 0;
  int done_seen = 0;

  // Index 0 = WRAP=1 board, index 1 = WRAP=0 board.
  logic mb [2][ROWS][COLS];
  int   mgen = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done != 2'b00) done_seen++;

  life_engine #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .step(step), .load_en(load_en), .load_x(load_x),
    .load_y(load_y), .load_val(load_val), .rd_x(rd_x), .rd_y(rd_y),
    .rd_alive(rd_alive[0]), .busy(busy[0]), .done(done[0]), .gen_count(gc_w)
  );

  life_engine #(.WRAP(0)) dut_flat (
    .clk(clk), .rst(rst), .step(step), .load_en(load_en), .load_x(load_x),
    .load_y(load_y), .load_val(load_val), .rd_x(rd_x), .rd_y(rd_y),
    .rd_alive(rd_alive[1]), .busy(busy[1]), .done(done[1]), .gen_count(gc_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic next_cell(input int w, input int x, input int y);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        int xx = x + dx;
        int yy = y + dy;
        if (dx == 0 && dy == 0) continue;
        if (w == 0) begin
          xx = (xx + COLS) % COLS;
          yy = (yy + ROWS) % ROWS;
        end else if (xx < 0 || xx >= COLS || yy < 0 || yy >= ROWS) begin
          continue;
        end
        if (mb[w][yy][xx]) n++;
      end
    end
    return (n == 3) || (mb[w][y][x] && n == 2);
  endfunction

  task automatic model_step();
    logic t [2][ROWS][COLS];
    for (int w = 0; w < 2; w++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          t[w][y][x] = next_cell(w, x, y);
    mb   = t;
    mgen = (mgen + 1) % 65536;
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          mb[w][y][x] = 1'b0;
    mgen = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic load_cell(input int x, input int y, input logic v);
    load_x   = 5'(x);
    load_y   = 4'(y);
    load_val = v;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
    if (x < COLS && y < ROWS) begin
      mb[0][y][x] = v;
      mb[1][y][x] = v;
    end
  endtask

  task automatic peek(input int w, input int x, input int y, output logic v);
    rd_x = 5'(x);
    rd_y = 4'(y);
    #1;
    v = rd_alive[w];
  endtask

  task automatic check_board(input string tag);
    for (int w = 0; w < 2; w++) begin
      int errs = 0;
      for (int y = 0; y < ROWS; y++) begin
        for (int x = 0; x < COLS; x++) begin
          rd_x = 5'(x);
          rd_y = 4'(y);
          #1;
          if (rd_alive[w] !== mb[w][y][x]) errs++;
        end
      end
      check($sformatf("%s %s bad cells", tag, (w == 0) ? "wrap" : "flat"), errs, 0);
    end
    tick();
  endtask

  task automatic check_status(input string tag);
    check({tag, " busy"}, busy, 2'b00);
    check({tag, " done"}, done, 2'b00);
    check({tag, " gen wrap"}, gc_w, mgen);
    check({tag, " gen flat"}, gc_n, mgen);
  endtask

  task automatic run_gen(input string tag, input int exp_lat);
    int n;
    step = 1'b1;
    #1;
    check({tag, " busy at step"}, busy, 2'b00);
    tick();
    step = 1'b0;
    n = 1;
    check({tag, " busy in scan"}, busy, 2'b11);
    while (done[0] !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " done flat"}, done[1], 1'b1);
    tick();
    model_step();
    check_status(tag);
    check_board(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic v;
    int n, chx, chy, d0;

    #2;
    do_reset();
    check_status("reset");
    check_board("reset");

    // Blinker, plus out-of-range loads and reads.
    load_cell(5, 5, 1'b1);
    load_cell(6, 5, 1'b1);
    load_cell(7, 5, 1'b1);
    load_cell(20, 5, 1'b1);
    load_cell(5, 15, 1'b1);
    check_board("blinker seed");
    peek(0, 21, 5, v);  check("rd x out of range", v, 1'b0);
    peek(0, 5, 15, v);  check("rd y out of range", v, 1'b0);
    tick();
    run_gen("blinker gen1", 301);
    peek(0, 6, 4, v);   check("blinker (6,4)", v, 1'b1);
    peek(0, 5, 5, v);   check("blinker (5,5)", v, 1'b0);
    tick();
    run_gen("blinker gen2", 301);

    // Block still life.
    do_reset();
    load_cell(2, 2, 1'b1);
    load_cell(3, 2, 1'b1);
    load_cell(2, 3, 1'b1);
    load_cell(3, 3, 1'b1);
    for (int g = 0; g < 3; g++) run_gen($sformatf("block gen%0d", g + 1), 301);
    peek(0, 3, 3, v);   check("block (3,3)", v, 1'b1);
    tick();

    // Corner seeds: wrap revives (0,0), flat kills everything.
    do_reset();
    load_cell(19, 0, 1'b1);
    load_cell(0, 14, 1'b1);
    load_cell(19, 14, 1'b1);
    run_gen("corners", 301);
    peek(0, 0, 0, v);   check("corner wrap (0,0)", v, 1'b1);
    peek(1, 0, 0, v);   check("corner flat (0,0)", v, 1'b0);
    peek(1, 19, 14, v); check("corner flat (19,14)", v, 1'b0);
    tick();

    // Glider across the wrap seam.
    do_reset();
    load_cell(19, 0, 1'b1);
    load_cell(0, 1, 1'b1);
    load_cell(18, 2, 1'b1);
    load_cell(19, 2, 1'b1);
    load_cell(0, 2, 1'b1);
    for (int g = 0; g < 4; g++) run_gen($sformatf("glider gen%0d", g + 1), 301);
    peek(0, 0, 1, v);   check("glider (0,1)", v, 1'b1);
    peek(0, 1, 2, v);   check("glider (1,2)", v, 1'b1);
    peek(0, 19, 3, v);  check("glider (19,3)", v, 1'b1);
    peek(0, 0, 3, v);   check("glider (0,3)", v, 1'b1);
    peek(0, 1, 3, v);   check("glider (1,3)", v, 1'b1);
    tick();

    // Random soup with a dead 5x5 hole around (10,10).
    do_reset();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if ((x < 8 || x > 12 || y < 8 || y > 12) && $urandom_range(0, 2) == 0)
          load_cell(x, y, 1'b1);
    check_board("soup seed");

    // Protocol: step and load during scan are ignored; display holds old board.
    chx = -1;
    chy = -1;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (chx < 0 && next_cell(0, x, y) != mb[0][y][x]) begin
          chx = x;
          chy = y;
        end
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (49) tick();
    step = 1'b1;
    load_en = 1'b1;
    load_x = 5'd10;
    load_y = 4'd10;
    load_val = 1'b1;
    tick();
    step = 1'b0;
    load_en = 1'b0;
    check("proto busy mid-scan", busy, 2'b11);
    check_board("proto mid-scan");
    n = 0;
    while (done[0] !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check("proto done seen", done[0], 1'b1);
    if (chx >= 0) begin
      peek(0, chx, chy, v);
      check("proto old during swap", v, mb[0][chy][chx]);
    end
    tick();
    model_step();
    if (chx >= 0) begin
      check("proto new after swap", rd_alive[0], mb[0][chy][chx]);
    end
    check_status("proto");
    check_board("proto");
    peek(0, 10, 10, v); check("proto (10,10) wrap", v, 1'b0);
    peek(1, 10, 10, v); check("proto (10,10) flat", v, 1'b0);
    tick();
    check("proto no retrigger", busy, 2'b00);

    // Back-to-back: step held high.
    step = 1'b1;
    tick();
    n = 1;
    while (done[0] !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check("b2b first latency", n, 301);
    model_step();
    n = 0;
    do begin
      tick();
      n++;
    end while (done[0] !== 1'b1 && n < 1000);
    check("b2b spacing", n, 302);
    step = 1'b0;
    tick();
    model_step();
    check_status("b2b");
    check_board("b2b");
    check("b2b idle after", busy, 2'b00);

    run_gen("soup extra", 301);

    // Reset in the middle of a scan.
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (119) tick();
    d0 = done_seen;
    rst = 1'b1;
    #1;
    clear_model();
    check("abort busy", busy, 2'b00);
    check("abort done", done, 2'b00);
    check("abort gen wrap", gc_w, 16'd0);
    check("abort gen flat", gc_n, 16'd0);
    tick();
    rst = 1'b0;
    check_board("abort board");
    repeat (400) tick();
    check("abort no done", done_seen, d0);
    check_status("abort end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
